// File: rtl/dco_freq_meter.sv
// Oscillator frequency meter: counts synchronized rising edges of dco_in over a
// programmable window of clk cycles and reports the count with a valid/ack handshake.
module dco_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              dco_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              continuous,
    input  logic              ack,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(1);
    localparam logic [CNT_W-1:0]  ACC_ONE     = CNT_W'(1);
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SYNC_STAGES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [GATE_W-1:0]      cnt_q, cnt_d;
    logic [GATE_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   rise;

    // dco_in enters through a plain flop chain; the last stage feeds the edge detector.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], dco_in};
        edge_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q & ~ack;

        if (!ena) begin
            // Abort keeps the last published result; only the live window is dropped.
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (gate_cycles != '0)) begin
                        len_d   = gate_cycles;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        valid_d = 1'b0;
                        cnt_d   = SETTLE_LAST;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    // Rises here are stale synchronizer contents and are dropped.
                    if (cnt_q == '0) begin
                        cnt_d   = len_q - GATE_ONE;
                        state_d = GATE;
                    end else begin
                        cnt_d = cnt_q - GATE_ONE;
                    end
                end
                GATE: begin
                    if (rise) begin
                        if (&acc_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = acc_q + ACC_ONE;
                        end
                    end
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - GATE_ONE;
                    end
                end
                DONE: begin
                    count_d    = acc_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                    if (continuous) begin
                        // Synchronizer is already primed, so restart straight into GATE.
                        cnt_d   = len_q - GATE_ONE;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = GATE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            edge_q     <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dco_freq_meter.sv
// Randomized scoreboard bench for dco_freq_meter: the expected count of each window is
// the number of 0->1 transitions in the per-edge samples of dco_in covering that window.
module tb_dco_freq_meter;

    localparam int CNT_W  = 8;
    localparam int GATE_W = 16;
    localparam int S      = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              dco_in = 1'b0;
    logic              start = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic              continuous = 1'b0;
    logic              ack = 1'b0;
    logic [CNT_W-1:0]  count;
    logic              valid;
    logic              busy;
    logic              overflow;

    dco_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in), .start(start),
        .gate_cycles(gate_cycles), .continuous(continuous), .ack(ack),
        .count(count), .valid(valid), .busy(busy), .overflow(overflow)
    );

    always #10 clk = ~clk;

    typedef struct {
        int n0;
        int g;
        int pub;
    } win_t;

    win_t sb[$];
    win_t mw;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   samp[0:32767];
    int   last_cnt = 0;
    int   last_ovf = 0;
    int   dmode = 1;
    int   dhi = 2;
    int   dlo = 2;
    int   ph = 0;
    bit   dlevel = 1'b0;
    bit   prev_v = 1'b0;
    int   mexp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Rising transitions between consecutive edge samples n0..n0+g.
    function automatic int rises(input int n0, input int g);
        int c = 0;
        for (int j = 0; j < g; j++)
            if (samp[n0+j+1] && !samp[n0+j]) c++;
        return c;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (cyc < 32768) samp[cyc] = dco_in;
    end

    // Oscillator model: dmode 1 = dhi/dlo-cycle square wave, 2 = random bits, else static.
    always @(negedge clk) begin
        case (dmode)
            1: begin
                ph++;
                if (dco_in ? (ph >= dhi) : (ph >= dlo)) begin
                    dco_in = ~dco_in;
                    ph = 0;
                end
            end
            2: dco_in = 1'($urandom_range(0, 1));
            default: dco_in = dlevel;
        endcase
    end

    // Monitor: a result must appear exactly on its scheduled edge and nowhere else.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0 && sb[0].pub == cyc) begin
            mw = sb.pop_front();
            mexp = rises(mw.n0, mw.g);
            chk("valid_at_done", 32'(valid), 32'd1);
            chk("count", 32'(count), 32'((mexp > CMAX) ? CMAX : mexp));
            chk("overflow", 32'(overflow), 32'(mexp > CMAX));
            last_cnt = (mexp > CMAX) ? CMAX : mexp;
            last_ovf = (mexp > CMAX) ? 1 : 0;
        end else begin
            chk("no_unscheduled_valid_rise", 32'(valid & ~prev_v), 32'd0);
        end
        prev_v = valid;
    end

    task automatic do_start(input int g, input bit cont, output int n0);
        @(negedge clk);
        start = 1'b1;
        gate_cycles = GATE_W'(g);
        continuous = cont;
        n0 = cyc + 1;
        if (g != 0) sb.push_back('{n0, g, n0 + S + g + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(g != 0));
        if (g != 0) chk("valid_cleared_on_start", 32'(valid), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("result_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_clears_valid", 32'(valid), 32'd0);
        chk("ack_count_held", 32'(count), 32'(last_cnt));
        chk("ack_ovf_held", 32'(overflow), 32'(last_ovf));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        int  g;
        bit  vb;

        // Reset with a toggling oscillator.
        dmode = 1; dhi = 2; dlo = 2;
        repeat (5) begin
            @(negedge clk);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
        end
        rst_n = 1'b1;
        ena = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // Single shot, 80 ns oscillator, 100-cycle window.
        do_start(100, 1'b0, n0);
        wait_done();
        chk("single_busy_low", 32'(busy), 32'd0);
        chk("single_count_range", 32'(count >= 8'd24 && count <= 8'd26), 32'd1);
        pulse_ack();

        // Static input low, then high.
        dmode = 0; dlevel = 1'b0;
        repeat (3) @(negedge clk);
        do_start(50, 1'b0, n0);
        wait_done();
        chk("static0_count", 32'(count), 32'd0);
        dlevel = 1'b1;
        repeat (3) @(negedge clk);
        do_start(50, 1'b0, n0);
        wait_done();
        chk("static1_count", 32'(count), 32'd0);
        chk("static1_valid", 32'(valid), 32'd1);

        // Zero-length request is ignored.
        vb = valid;
        do_start(0, 1'b0, n0);
        chk("zero_gate_valid", 32'(valid), 32'(vb));

        // Saturation, then a normal window.
        dmode = 1; dhi = 2; dlo = 2;
        do_start(2000, 1'b0, n0);
        wait_done();
        chk("sat_count", 32'(count), 32'(CMAX));
        chk("sat_overflow", 32'(overflow), 32'd1);
        do_start(400, 1'b0, n0);
        wait_done();
        chk("post_sat_overflow", 32'(overflow), 32'd0);

        // Continuous mode, 60 ns oscillator, four windows of 64.
        dhi = 1; dlo = 2;
        do_start(64, 1'b1, n0);
        for (int k = 1; k < 4; k++)
            sb.push_back('{n0 + k*65, 64, n0 + k*65 + S + 65});
        wait_cyc(n0 + S + 65);
        pulse_ack();
        wait_cyc(n0 + 100);
        start = 1'b1;
        gate_cycles = GATE_W'(7);
        @(negedge clk);
        start = 1'b0;
        chk("start_while_busy", 32'(busy), 32'd1);
        wait_cyc(n0 + 65 + S + 64);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_with_done_valid", 32'(valid), 32'd1);
        wait_cyc(n0 + 3*65 + S + 2);
        continuous = 1'b0;
        wait_done();
        chk("cont_end_busy", 32'(busy), 32'd0);

        // Enable abort mid-window.
        dhi = 2; dlo = 2;
        do_start(200, 1'b0, n0);
        wait_cyc(n0 + S + 50);
        ena = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("ena_abort_busy", 32'(busy), 32'd0);
        chk("ena_abort_valid", 32'(valid), 32'd0);
        chk("ena_abort_count", 32'(count), 32'(last_cnt));
        chk("ena_abort_ovf", 32'(overflow), 32'(last_ovf));
        ena = 1'b1;
        do_start(60, 1'b0, n0);
        wait_done();

        // Asynchronous reset mid-window, then a clean restart.
        do_start(200, 1'b0, n0);
        wait_cyc(n0 + S + 30);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        last_cnt = 0;
        last_ovf = 0;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start(80, 1'b0, n0);
        wait_done();

        // Randomized windows and oscillator patterns.
        for (int i = 0; i < 10; i++) begin
            dmode = (($urandom % 3) == 0) ? 2 : 1;
            dhi = $urandom_range(1, 5);
            dlo = $urandom_range(1, 5);
            g = (i == 0) ? 1 : $urandom_range(1, 150);
            do_start(g, 1'b0, n0);
            wait_done();
            chk("rand_busy_low", 32'(busy), 32'd0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
